// File: rtl/arm_prog_loader.sv
// arm_prog_loader: streams 32-bit words into memory port 2 at consecutive
// word addresses while holding arm_core in reset. It releases the core once
// the load completes and then watches halted.
// Optional build macro ARM_LOADER_CHECKSUM_EN: when defined, the in_last beat
// carries a 32-bit sum of all written words and is never written to memory.
// The loader releases the core only if that sum matches. When the macro is
// undefined, the in_last beat is an ordinary data word.
module arm_prog_loader #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned MEM_BYTES = 4096
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        in_valid,
  input  logic [31:0] in_data,
  input  logic        in_last,
  output logic        in_ready,
  input  logic        halted,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_data_in,
  output logic        mem_write_en,
  output logic        core_rst,
  output logic [15:0] word_count,
  output logic        done,
  output logic        error
);

  // Capacity in words; the word counter is compared against this.
  localparam logic [15:0] CAP_WORDS = 16'(MEM_BYTES / 4);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_FLUSH = 3'd2,
    S_RUN   = 3'd3,
    S_HALT  = 3'd4,
    S_ERROR = 3'd5
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] data_q, data_d;
  logic        we_q, we_d;
  logic [15:0] wc_q, wc_d;
  logic        core_rst_q, core_rst_d;
  logic        done_q, done_d;
  logic        error_q, error_d;
  logic        accept_s;
  logic        has_room_s;
`ifdef ARM_LOADER_CHECKSUM_EN
  logic [31:0] sum_q, sum_d;
`endif

  // Byte address of word n of the image; wraps modulo 2^32 by construction.
  function automatic logic [31:0] word_addr(input logic [15:0] n);
    word_addr = BASE_ADDR + {14'd0, n, 2'b00};
  endfunction

  assign accept_s   = in_valid && (state_q == S_LOAD);
  assign has_room_s = (wc_q < CAP_WORDS);

  // Next-state, write-port and counter logic.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    data_d  = data_q;
    we_d    = 1'b0;
    wc_d    = wc_q;
`ifdef ARM_LOADER_CHECKSUM_EN
    sum_d   = sum_q;
`endif
    case (state_q)
      S_IDLE, S_HALT, S_ERROR: begin
        if (start) begin
          state_d = S_LOAD;
          wc_d    = 16'd0;
`ifdef ARM_LOADER_CHECKSUM_EN
          sum_d   = 32'd0;
`endif
        end else begin
          state_d = state_q;
        end
      end
      S_LOAD: begin
        if (accept_s) begin
`ifdef ARM_LOADER_CHECKSUM_EN
          if (in_last) begin
            // Checksum beat: compared, never written, exempt from capacity.
            if (sum_q == in_data) begin
              state_d = S_FLUSH;
            end else begin
              state_d = S_ERROR;
            end
          end else if (has_room_s) begin
            addr_d = word_addr(wc_q);
            data_d = in_data;
            we_d   = 1'b1;
            wc_d   = wc_q + 16'd1;
            sum_d  = sum_q + in_data;
          end else begin
            state_d = S_ERROR;
          end
`else
          if (has_room_s) begin
            addr_d = word_addr(wc_q);
            data_d = in_data;
            we_d   = 1'b1;
            wc_d   = wc_q + 16'd1;
            if (in_last) begin
              state_d = S_FLUSH;
            end else begin
              state_d = S_LOAD;
            end
          end else begin
            state_d = S_ERROR;
          end
`endif
        end else begin
          state_d = S_LOAD;
        end
      end
      S_FLUSH: begin
        // Gives the final write its cycle before the core leaves reset.
        state_d = S_RUN;
      end
      S_RUN: begin
        if (halted) begin
          state_d = S_HALT;
        end else begin
          state_d = S_RUN;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Status outputs follow the state being entered, so they are registered
  // alongside it and change on the same edge.
  always_comb begin
    core_rst_d = 1'b1;
    done_d     = 1'b0;
    error_d    = 1'b0;
    case (state_d)
      S_RUN: begin
        core_rst_d = 1'b0;
      end
      S_HALT: begin
        core_rst_d = 1'b0;
        done_d     = 1'b1;
      end
      S_ERROR: begin
        error_d = 1'b1;
      end
      default: begin
        core_rst_d = 1'b1;
      end
    endcase
  end

  // State and output registers; synchronous reset drops any write in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      addr_q     <= 32'd0;
      data_q     <= 32'd0;
      we_q       <= 1'b0;
      wc_q       <= 16'd0;
      core_rst_q <= 1'b1;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
`ifdef ARM_LOADER_CHECKSUM_EN
      sum_q      <= 32'd0;
`endif
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      we_q       <= we_d;
      wc_q       <= wc_d;
      core_rst_q <= core_rst_d;
      done_q     <= done_d;
      error_q    <= error_d;
`ifdef ARM_LOADER_CHECKSUM_EN
      sum_q      <= sum_d;
`endif
    end
  end

  assign in_ready     = (state_q == S_LOAD);
  assign mem_addr     = addr_q;
  assign mem_data_in  = data_q;
  assign mem_write_en = we_q;
  assign core_rst     = core_rst_q;
  assign word_count   = wc_q;
  assign done         = done_q;
  assign error        = error_q;

endmodule

// File: tb/tb_arm_prog_loader.sv
// Self-checking bench for arm_prog_loader. It drives directed and randomized
// program streams and checks every cycle against expectations that are
// derived from the image being loaded. Works with or without
// ARM_LOADER_CHECKSUM_EN.
module tb_arm_prog_loader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, start, in_valid, in_last, halted;
  logic [31:0] in_data;

  logic        m_ready, m_we, m_crst, m_done, m_err;
  logic [31:0] m_addr, m_data;
  logic [15:0] m_wc;
  logic        s_ready, s_we, s_crst, s_done, s_err;
  logic [31:0] s_addr, s_data;
  logic [15:0] s_wc;

  arm_prog_loader #(.BASE_ADDR(32'h0000_0000), .MEM_BYTES(4096)) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_last(in_last), .in_ready(m_ready), .halted(halted), .mem_addr(m_addr),
    .mem_data_in(m_data), .mem_write_en(m_we), .core_rst(m_crst),
    .word_count(m_wc), .done(m_done), .error(m_err));

  arm_prog_loader #(.BASE_ADDR(32'h0000_0000), .MEM_BYTES(8)) dut_small (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_last(in_last), .in_ready(s_ready), .halted(halted), .mem_addr(s_addr),
    .mem_data_in(s_data), .mem_write_en(s_we), .core_rst(s_crst),
    .word_count(s_wc), .done(s_done), .error(s_err));

  // Selects which instance is being checked (0 = 4 KiB, 1 = 8 bytes).
  bit sel;
  logic        o_ready, o_we, o_crst, o_done, o_err;
  logic [31:0] o_addr, o_data;
  logic [15:0] o_wc;
  assign o_ready = sel ? s_ready : m_ready;
  assign o_we    = sel ? s_we    : m_we;
  assign o_crst  = sel ? s_crst  : m_crst;
  assign o_done  = sel ? s_done  : m_done;
  assign o_err   = sel ? s_err   : m_err;
  assign o_addr  = sel ? s_addr  : m_addr;
  assign o_data  = sel ? s_data  : m_data;
  assign o_wc    = sel ? s_wc    : m_wc;

  int n_vec = 0;
  int n_err = 0;

  // Expected outputs, updated from the image and the directed sequence.
  logic        exp_ready, exp_we, exp_crst, exp_done, exp_err;
  logic [31:0] exp_addr, exp_data;
  logic [15:0] exp_wc;
  // Attributes of the beat currently presented.
  logic        beat_wr;
  logic [31:0] beat_addr;
  logic [31:0] prog[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic set_reset_exp();
    exp_ready = 1'b0; exp_we = 1'b0; exp_crst = 1'b1; exp_done = 1'b0;
    exp_err = 1'b0; exp_addr = 32'd0; exp_data = 32'd0; exp_wc = 16'd0;
  endtask

  // One clock: check all outputs mid-cycle, then advance expectations.
  task automatic step();
    bit acc;
    @(negedge clk);
    check("in_ready",     {31'd0, o_ready}, {31'd0, exp_ready});
    check("mem_write_en", {31'd0, o_we},    {31'd0, exp_we});
    check("mem_addr",     o_addr,           exp_addr);
    check("mem_data_in",  o_data,           exp_data);
    check("word_count",   {16'd0, o_wc},    {16'd0, exp_wc});
    check("core_rst",     {31'd0, o_crst},  {31'd0, exp_crst});
    check("done",         {31'd0, o_done},  {31'd0, exp_done});
    check("error",        {31'd0, o_err},   {31'd0, exp_err});
    acc = in_valid && exp_ready && !rst;
    @(posedge clk);
    if (rst) begin
      set_reset_exp();
    end else if (acc && beat_wr) begin
      exp_we   = 1'b1;
      exp_addr = beat_addr;
      exp_data = in_data;
      exp_wc   = exp_wc + 16'd1;
    end else begin
      exp_we = 1'b0;
    end
    #1;
  endtask

  // Reset without checks; used when the checked instance's state is unknown.
  // start and in_valid are high to show that reset wins.
  task automatic hard_reset();
    rst = 1'b1; start = 1'b1; in_valid = 1'b1; in_last = 1'b0; halted = 1'b0;
    in_data = $urandom; beat_wr = 1'b0; beat_addr = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0; start = 1'b0; in_valid = 1'b0;
    set_reset_exp();
  endtask

  // Start a load, stream the image (plus checksum beat when enabled) with
  // optional random gaps, and follow it to RUN or ERROR.
  task automatic do_load(input int cap, input int max_gap, input bit corrupt, input bit noise);
    int          wc, nbeats, g;
    logic [31:0] sum, d;
    bit          last_b, wr_b, failed, terminal;
    wc = 0; sum = 32'd0; failed = 1'b0; terminal = 1'b0;
    start = 1'b1; step(); start = 1'b0;
    exp_ready = 1'b1; exp_wc = 16'd0; exp_crst = 1'b1; exp_done = 1'b0; exp_err = 1'b0;
`ifdef ARM_LOADER_CHECKSUM_EN
    nbeats = prog.size() + 1;
`else
    nbeats = prog.size();
`endif
    for (int i = 0; i < nbeats && !terminal; i++) begin
      g = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
      for (int j = 0; j < g; j++) begin
        in_valid = 1'b0; in_data = $urandom; in_last = 1'($urandom_range(1, 0));
        start = noise ? 1'($urandom_range(1, 0)) : 1'b0;
        beat_wr = 1'b0;
        step();
      end
      start  = 1'b0;
      last_b = (i == nbeats - 1);
`ifdef ARM_LOADER_CHECKSUM_EN
      if (last_b) begin
        d = corrupt ? sum + 32'd1 : sum;
        wr_b = 1'b0;
        failed = corrupt;
      end else begin
        d = prog[i];
        wr_b = (wc < cap);
        failed = !wr_b;
      end
`else
      d = prog[i];
      wr_b = (wc < cap) && !(corrupt && 1'b0);
      failed = !wr_b;
`endif
      terminal  = last_b || failed;
      in_valid  = 1'b1; in_data = d; in_last = last_b;
      beat_wr   = wr_b; beat_addr = 32'(wc * 4);
      step();
      if (wr_b) begin
        wc++;
        sum = sum + d;
      end
    end
    in_valid = 1'b0; in_last = 1'b0; beat_wr = 1'b0;
    exp_ready = 1'b0;
    if (failed) exp_err = 1'b1;
    step();
    if (!failed) exp_crst = 1'b0;
    step();
    step();
  endtask

  // In RUN: start is ignored, then halted moves to HALT with done set.
  task automatic do_halt();
    start = 1'b1; step(); start = 1'b0; step();
    halted = 1'b1; step(); halted = 1'b0;
    exp_done = 1'b1;
    step(); step();
  endtask

  initial begin
    sel = 1'b0;
    hard_reset();
    // Reset state; in_valid without start must not be accepted.
    in_valid = 1'b1; in_data = 32'hDEAD_BEEF;
    step(); step();
    in_valid = 1'b0;

    // Basic back-to-back load.
    prog = '{32'h24010005, 32'h24020007, 32'h0000000C};
    do_load(1024, 0, 1'b0, 1'b0);

    // Halt, then randomized gapped reloads from HALT.
    for (int k = 0; k < 4; k++) begin
      do_halt();
      prog.delete();
      for (int w = 0; w < int'($urandom_range(6, 1)); w++) prog.push_back($urandom);
      do_load(1024, 3, 1'b0, 1'b1);
    end

`ifdef ARM_LOADER_CHECKSUM_EN
    do_halt();
    prog = '{32'h1, 32'h2};
    do_load(1024, 0, 1'b1, 1'b0);
    prog.delete();
    do_load(1024, 1, 1'b0, 1'b0);
    do_halt();
`endif

    // Reset in the cycle after the second acceptance.
    do_halt();
    start = 1'b1; step(); start = 1'b0;
    exp_ready = 1'b1; exp_wc = 16'd0; exp_crst = 1'b1; exp_done = 1'b0;
    for (int b = 0; b < 2; b++) begin
      in_valid = 1'b1; in_data = $urandom; in_last = 1'b0;
      beat_wr = 1'b1; beat_addr = 32'(b * 4);
      step();
    end
    rst = 1'b1; in_valid = 1'b0; beat_wr = 1'b0;
    step();
    rst = 1'b0; in_valid = 1'b1; in_data = $urandom;
    repeat (3) step();
    in_valid = 1'b0;

    // Overflow on the 8-byte instance, then recovery from ERROR.
    sel = 1'b1;
    hard_reset();
    step();
    prog = '{32'h11111111, 32'h22222222, 32'h33333333};
    do_load(2, 0, 1'b0, 1'b0);
    prog = '{$urandom, $urandom};
    do_load(2, 2, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/arm_prog_loader.md
# arm_prog_loader

Synthesizable program loader that sits directly upstream of `arm_memory` data port 2 and the `arm_core` reset input. It accepts a stream of 32-bit instruction/data words over a valid/ready handshake, writes them to consecutive word addresses while holding the core in reset, then releases the core and watches `halted`. It replaces the file-driven load sequence with hardware usable on FPGA (UART/JTAG bridge upstream).

## Interface

- `BASE_ADDR`, 32'h0000_0000, byte address of the first written word
- `MEM_BYTES`, 4096, program capacity in bytes; must be a multiple of 4
- `clk`  in  1  system clock, all logic on rising edge
- `rst`  in  1  synchronous, active-high reset
- `start`  in  1  single-cycle request to begin a load
- `in_valid`  in  1  upstream word valid
- `in_data`  in  32  upstream word
- `in_last`  in  1  marks final beat of the program
- `in_ready`  out  1  loader accepts a beat this cycle
- `halted`  in  1  from `arm_core`
- `mem_addr`  out  32  byte address to memory port 2
- `mem_data_in`  out  32  write data to memory port 2
- `mem_write_en`  out  1  write strobe to memory port 2 (drives `we[1]`)
- `core_rst`  out  1  reset to `arm_core`, active-high
- `word_count`  out  16  words written in current/last load
- `done`  out  1  core halted after a successful load (sticky)
- `error`  out  1  load aborted (sticky)

## Operation

- States: IDLE, LOAD, FLUSH, RUN, HALT, ERROR.
- Reset values: state IDLE, `core_rst`=1, `mem_write_en`=0, `mem_addr`=0, `mem_data_in`=0, `word_count`=0, `done`=0, `error`=0, `in_ready`=0.
- IDLE: `core_rst`=1. `start` → LOAD, `word_count`←0.
- LOAD: `in_ready`=1 (combinational, = state==LOAD). Beat accepted when `in_valid && in_ready`.
  - Accepted data beat with `word_count` < MEM_BYTES/4: next cycle `mem_addr`=BASE_ADDR+4·`word_count`, `mem_data_in`=`in_data`, `mem_write_en`=1 for exactly one cycle; `word_count`+1.
  - Accepted data beat with `word_count` == MEM_BYTES/4: no write, → ERROR.
  - Accepted beat with `in_last`=1: → FLUSH (after its write, if a data beat).
  - `start` ignored.
- FLUSH: one cycle; final write completes; `core_rst` still 1. → RUN.
- RUN: `core_rst`=0. `halted` sampled 1 → HALT. `start` ignored.
- HALT: `done`=1, `core_rst`=0 (core state inspectable). `start` → LOAD with `core_rst`=1, `done`←0, `word_count`←0.
- ERROR: `error`=1, `core_rst`=1, no writes. `start` → LOAD, `error`←0.
- `mem_addr` wraps modulo 2^32 (only reachable with large BASE_ADDR; not flagged).
- `rst` mid-load: write in flight dropped (`mem_write_en` 0 next cycle), state IDLE; memory contents undefined for partial load.

## Timing

- Beat accepted at edge k → write strobe high in cycle after edge k.
- Last beat accepted at edge k → FLUSH after k, RUN (`core_rst`=0) after edge k+1.
- `halted` high at edge j → `done`=1 after edge j.
- Throughput: one word per cycle; `in_valid` gaps allowed, `in_data` sampled only on acceptance.
- `start` same cycle as `rst`: `rst` wins.

## Configuration

- `ARM_LOADER_CHECKSUM_EN` defined: the `in_last` beat is a checksum, never written. Loader keeps a running 32-bit sum (mod 2^32) of written words; on the last beat, sum == `in_data` → FLUSH, else → ERROR. `in_last` as first beat = empty program; valid iff checksum is 0. Checksum beat exempt from the capacity check.
- Not defined: `in_last` beat is an ordinary data word and is written; no sum logic.

## Test plan

- Basic load (macro off, BASE_ADDR 0): start, beats 0x24010005, 0x24020007, 0x0000000C(last) back-to-back → writes at 0,4,8 in consecutive cycles, `word_count`=3, `core_rst` falls 2 cycles after last acceptance.
- Gapped stream: same words with `in_valid` low 1–3 cycles between beats → identical writes, no extra strobes, `mem_write_en` never high two cycles for one beat.
- Halt/restart: drive `halted`=1 in RUN → `done`=1 next cycle, `core_rst` stays 0; pulse `start` → `core_rst`=1, `done`=0, new load from address 0.
- Overflow (MEM_BYTES 8): three beats → writes at 0,4 only, `error`=1, `core_rst` held 1, `in_ready`=0.
- Checksum (macro on): 0x1, 0x2, last 0x3 → two writes, RUN; repeat with last 0x4 → `error`=1, no release of `core_rst`.
- Reset mid-load: `rst` in cycle after 2nd acceptance → `mem_write_en`=0, all outputs at reset values next cycle, `start` required to reload.
